// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide beside the Execute-stage ALU.
// One shift-add or restoring-divide step per cycle; HI/LO written on the FIX exit edge.
module mul_div_unit #(
   parameter int         WIDTH    = 32,
   parameter logic [2:0] MUL_CODE = 3'b101,
   parameter logic [2:0] DIV_CODE = 3'b111
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StartE,
   input  logic [2:0]       ALUControlE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   output logic             BusyE,
   output logic             DoneE,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

   state_t             state;
   logic [5:0]         count;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;
   logic               div_zero;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;

   logic               accept;
   logic               op_div;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     add_hi;
   logic [WIDTH+1:0]   wide;
   logic [WIDTH+1:0]   diff;
   logic               ge;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   hi_fix;
   logic [WIDTH-1:0]   lo_fix;

   assign op_div = (ALUControlE == DIV_CODE);
   assign accept = StartE && ((ALUControlE == MUL_CODE) || op_div);
   assign abs_a  = SrcAE[WIDTH-1] ? -SrcAE : SrcAE;
   assign abs_b  = SrcBE[WIDTH-1] ? -SrcBE : SrcBE;

   // Multiply step: add multiplicand into the upper half when the current
   // multiplier bit is set; the carry lands in the shifted-out MSB.
   assign add_hi = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);

   // Divide step: bring down the next dividend bit and trial-subtract.
   assign wide = {rem, acc[WIDTH-1]};
   assign diff = wide - {2'b00, mag_b};
   assign ge   = ~diff[WIDTH+1];

   always_comb begin
      prod   = neg_lo ? -acc : acc;
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
      if (is_div) begin
         // Divide by zero yields quotient all ones; the remainder is already
         // |A| with the sign of A, i.e. the dividend itself.
         lo_fix = div_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
         hi_fix = neg_hi ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         acc      <= '0;
         rem      <= '0;
         BusyE    <= 1'b0;
         DoneE    <= 1'b0;
         HiOut    <= '0;
         LoOut    <= '0;
      end else begin
         DoneE <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= CALC;
                  count    <= '0;
                  is_div   <= op_div;
                  neg_lo   <= SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1];
                  neg_hi   <= op_div & SrcAE[WIDTH-1];
                  div_zero <= op_div & (SrcBE == '0);
                  mag_a    <= abs_a;
                  mag_b    <= abs_b;
                  acc      <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                  rem      <= '0;
                  BusyE    <= 1'b1;
               end
            end
            CALC: begin
               if (is_div) begin
                  rem              <= ge ? diff[WIDTH:0] : wide[WIDTH:0];
                  acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ge};
               end else begin
                  acc <= {add_hi, acc[WIDTH-1:1]};
               end
               if (count == LAST) state <= FIX;
               else               count <= count + 6'd1;
            end
            FIX: begin
               HiOut <= hi_fix;
               LoOut <= lo_fix;
               DoneE <= 1'b1;
               BusyE <= 1'b0;
               count <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks of mul_div_unit: results, fixed latency, busy window,
// ignored/invalid requests, back-to-back issue and reset abort.
module tb_mul_div_unit;

   localparam logic [2:0] MUL = 3'b101;
   localparam logic [2:0] DIV = 3'b111;

   logic        clk = 1'b0;
   logic        reset;
   logic        StartE;
   logic [2:0]  ALUControlE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        BusyE;
   logic        DoneE;
   logic [31:0] HiOut;
   logic [31:0] LoOut;

   int total = 0;
   int bad   = 0;

   mul_div_unit dut (
      .clk(clk), .reset(reset), .StartE(StartE), .ALUControlE(ALUControlE),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .BusyE(BusyE), .DoneE(DoneE),
      .HiOut(HiOut), .LoOut(LoOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the DoneE cycle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit poke);
      int lat = 0;
      int busy_cnt = 0;
      StartE = 1'b1; ALUControlE = op; SrcAE = a; SrcBE = b;
      @(posedge clk); #1;
      StartE = 1'b0; SrcAE = ~a; SrcBE = b + 32'd3; ALUControlE = (op == MUL) ? DIV : MUL;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (BusyE) busy_cnt++;
         if (poke && lat == 5) begin
            StartE = 1'b1; ALUControlE = DIV; SrcAE = 32'd999; SrcBE = 32'd4;
         end
         if (poke && lat == 6) StartE = 1'b0;
         if (DoneE) break;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd34);
      chk({tag, "_busy"}, 64'(busy_cnt), 64'd33);
      chk({tag, "_res"}, {HiOut, LoOut}, exp);
   endtask

   initial begin
      int dones;
      reset = 1'b1; StartE = 1'b0; ALUControlE = 3'b000; SrcAE = '0; SrcBE = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", {30'd0, BusyE, DoneE, HiOut, LoOut}, 66'd0);

      // reset and start together: request dropped
      StartE = 1'b1; ALUControlE = MUL; SrcAE = 32'd3; SrcBE = 32'd4;
      @(posedge clk); #1;
      reset = 1'b0; StartE = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", 64'(BusyE), 64'd0);

      run_op("mul_7x-3", MUL, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
      @(negedge clk);
      run_op("mul_min2", MUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
      @(negedge clk);
      run_op("mul_m1m1", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);
      @(negedge clk);
      run_op("mul_1000", MUL, 32'd1000, 32'd1000, 64'h00000000_000F4240, 1'b0);
      @(negedge clk);
      run_op("div_-7_2", DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
      @(negedge clk);
      run_op("div_-100_-7", DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0);
      @(negedge clk);
      run_op("div_5_0", DIV, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b0);
      @(negedge clk);
      run_op("div_-8_0", DIV, 32'hFFFFFFF8, 32'd0, 64'hFFFFFFF8_FFFFFFFF, 1'b0);
      @(negedge clk);
      run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
      @(negedge clk);

      // mid-operation StartE with other operands is ignored
      run_op("mul_poke", MUL, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b1);
      @(negedge clk);

      // back-to-back: second request issued in the DoneE cycle
      run_op("div_100_-7", DIV, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0);
      run_op("b2b_mul", MUL, 32'hFFFFFFFB, 32'd6, 64'hFFFFFFFF_FFFFFFE2, 1'b0);
      chk("b2b_hold", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFE2);
      @(negedge clk);

      // invalid op code: no accept, HI/LO hold
      StartE = 1'b1; ALUControlE = 3'b010; SrcAE = 32'd9; SrcBE = 32'd9;
      @(posedge clk); #1;
      StartE = 1'b0;
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (BusyE || DoneE) dones++;
      end
      chk("bad_op_idle", 64'(dones), 64'd0);
      chk("bad_op_hold", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFE2);

      // reset at cycle N+10 of a multiply aborts it
      StartE = 1'b1; ALUControlE = MUL; SrcAE = 32'd11; SrcBE = 32'd13;
      @(posedge clk); #1;
      StartE = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_state", {31'd0, BusyE, HiOut, LoOut}, 96'd0);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (DoneE || BusyE) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
